// File: rtl/data_hazard_scoreboard_pkg.sv
// Shared types for the processing-unit hazard logic.
//   reg_index_t     : GPR index (r0..r31)
//   spr_reduced_t   : compact SPR id used by decode and the SPR slot array
//   fu_port_t       : functional-unit port selector
//   hazard_count_t  : pending-write countdown value, wide enough for the
//                     default latencies below
package data_hazard_scoreboard_pkg;

  localparam int NUM_GPRS      = 32;
  localparam int NUM_CR_FIELDS = 8;
  localparam int SPR_ID_W      = 4;

  localparam int DEF_ALU_LATENCY = 3;
  localparam int DEF_MEM_LATENCY = 5;
  localparam int DEF_SPR_LATENCY = 3;
  localparam int DEF_READ_SLACK  = 0;
  localparam int DEF_SPR_SLOTS   = 2;

  typedef logic [4:0]          reg_index_t;
  typedef logic [SPR_ID_W-1:0] spr_reduced_t;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_MEM    = 2'd1,
    FU_SPR    = 2'd2,
    FU_BRANCH = 2'd3
  } fu_port_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DEF_MAX_LATENCY =
    max_int(max_int(DEF_ALU_LATENCY, DEF_MEM_LATENCY), DEF_SPR_LATENCY);
  localparam int HAZARD_COUNT_W = $clog2(DEF_MAX_LATENCY + 1);

  typedef logic [HAZARD_COUNT_W-1:0] hazard_count_t;

endpackage

// File: rtl/data_hazard_ctrl_if.sv
// Resource usage of the instruction sitting in decode.
//   en                     : issue-valid for the decoded instruction
//   read_gpr_{a,b,c}/gpr_* : GPR source operands
//   read_cr_{0,1,2}        : CR-field read masks, bit i = CR field i
//   read_ctr/lnk/xer       : special register reads
//   read_spr(2)/_id        : SPR reads by reduced id
//   write_gpr_dest_alu/mem : GPR destinations written by the ALU / load path
//   write_cr               : CR-field write mask
//   write_ctr/lnk/xer      : special register writes
//   write_spr/_id          : SPR write by reduced id
// Handshake: en is a plain valid; there is no ready back to decode, the
// consumer answers with its own stall signal in the same cycle.
interface Data_hazard_ctrl_if;
  import data_hazard_scoreboard_pkg::*;

  logic         en;
  logic         read_gpr_a, read_gpr_b, read_gpr_c;
  reg_index_t   gpr_a, gpr_b, gpr_c;
  logic [7:0]   read_cr_0, read_cr_1, read_cr_2;
  logic         read_ctr, read_lnk, read_xer;
  logic         read_spr, read_spr2;
  spr_reduced_t read_spr_id, read_spr2_id;
  logic         write_gpr_dest_alu, write_gpr_dest_mem;
  reg_index_t   gpr_dest_alu, gpr_dest_mem;
  logic [7:0]   write_cr;
  logic         write_ctr, write_lnk, write_xer;
  logic         write_spr;
  spr_reduced_t write_spr_id;

  modport data_hazard_ctrl (
    input en, read_gpr_a, read_gpr_b, read_gpr_c, gpr_a, gpr_b, gpr_c,
          read_cr_0, read_cr_1, read_cr_2, read_ctr, read_lnk, read_xer,
          read_spr, read_spr2, read_spr_id, read_spr2_id,
          write_gpr_dest_alu, write_gpr_dest_mem, gpr_dest_alu, gpr_dest_mem,
          write_cr, write_ctr, write_lnk, write_xer, write_spr, write_spr_id
  );

  modport decode (
    output en, read_gpr_a, read_gpr_b, read_gpr_c, gpr_a, gpr_b, gpr_c,
           read_cr_0, read_cr_1, read_cr_2, read_ctr, read_lnk, read_xer,
           read_spr, read_spr2, read_spr_id, read_spr2_id,
           write_gpr_dest_alu, write_gpr_dest_mem, gpr_dest_alu, gpr_dest_mem,
           write_cr, write_ctr, write_lnk, write_xer, write_spr, write_spr_id
  );
endinterface

// File: rtl/hazard_counter.sv
// Loadable down-counter that saturates at zero; one per tracked resource.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load load_value this cycle (wins over the decrement)
//   load_value : latency of the write being issued
//   count      : remaining cycles until the write lands
//   busy       : count != 0
module hazard_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count,
  output logic         busy
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/data_hazard_scoreboard.sv
// Tracks in-flight register writes and holds decode while the instruction
// it presents would read, or overtake with a shorter write, a pending result.
//   clk, reset : clock, asynchronous active-high reset
//   ctrl       : resource usage of the decoded instruction, ctrl.en = valid
//   flush      : drop this cycle's issue, pending entries are kept
//   stall      : combinational hold for fetch/decode
//   busy_gpr   : per-GPR pending flag
module data_hazard_scoreboard
  import data_hazard_scoreboard_pkg::*;
#(
  parameter int ALU_LATENCY = DEF_ALU_LATENCY,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int SPR_LATENCY = DEF_SPR_LATENCY,
  parameter int READ_SLACK  = DEF_READ_SLACK,
  parameter int SPR_SLOTS   = DEF_SPR_SLOTS
) (
  input  logic                          clk,
  input  logic                          reset,
  Data_hazard_ctrl_if.data_hazard_ctrl  ctrl,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_GPRS-1:0]           busy_gpr
);

  localparam int LONG_LATENCY = max_int(ALU_LATENCY, MEM_LATENCY);
  localparam int CW = $clog2(max_int(LONG_LATENCY, SPR_LATENCY) + 1);

  localparam logic [CW-1:0] ALU_C   = CW'(ALU_LATENCY);
  localparam logic [CW-1:0] MEM_C   = CW'(MEM_LATENCY);
  localparam logic [CW-1:0] SPR_C   = CW'(SPR_LATENCY);
  localparam logic [CW-1:0] LONG_C  = CW'(LONG_LATENCY);
  localparam logic [CW-1:0] SLACK_C = CW'(READ_SLACK);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [CW-1:0]            gpr_count [NUM_GPRS];
  logic [CW-1:0]            gpr_value [NUM_GPRS];
  logic [NUM_GPRS-1:0]      gpr_load;
  logic [CW-1:0]            cr_count [NUM_CR_FIELDS];
  logic [NUM_CR_FIELDS-1:0] cr_busy;
  logic [NUM_CR_FIELDS-1:0] cr_load;
  logic [CW-1:0]            ctr_count, lnk_count, xer_count;
  logic                     ctr_busy, lnk_busy, xer_busy;

  logic [SPR_SLOTS-1:0]     slot_valid;
  spr_reduced_t             slot_id [SPR_SLOTS];
  logic [CW-1:0]            slot_count [SPR_SLOTS];
  logic [SPR_SLOTS-1:0]     slot_load;

  logic read_hazard, waw_hazard, slot_hazard, issue;
  logic spr_hit, spr_free;
  int   hit_idx, free_idx;

  // Reads compare against the registered counts, so an instruction that
  // reads and writes the same register never stalls on itself.
  always_comb begin
    read_hazard = 1'b0;
    if (ctrl.read_gpr_a && gpr_count[ctrl.gpr_a] > SLACK_C) read_hazard = 1'b1;
    if (ctrl.read_gpr_b && gpr_count[ctrl.gpr_b] > SLACK_C) read_hazard = 1'b1;
    if (ctrl.read_gpr_c && gpr_count[ctrl.gpr_c] > SLACK_C) read_hazard = 1'b1;
    for (int i = 0; i < NUM_CR_FIELDS; i++) begin
      if ((ctrl.read_cr_0[i] | ctrl.read_cr_1[i] | ctrl.read_cr_2[i]) &&
          cr_busy[i] && cr_count[i] > SLACK_C) read_hazard = 1'b1;
    end
    if (ctrl.read_ctr && ctr_busy && ctr_count > SLACK_C) read_hazard = 1'b1;
    if (ctrl.read_lnk && lnk_busy && lnk_count > SLACK_C) read_hazard = 1'b1;
    if (ctrl.read_xer && xer_busy && xer_count > SLACK_C) read_hazard = 1'b1;
    for (int s = 0; s < SPR_SLOTS; s++) begin
      if (slot_valid[s] && slot_count[s] > SLACK_C &&
          ((ctrl.read_spr  && slot_id[s] == ctrl.read_spr_id) ||
           (ctrl.read_spr2 && slot_id[s] == ctrl.read_spr2_id))) read_hazard = 1'b1;
    end
  end

  // A new write must not land before an older write to the same target.
  always_comb begin
    waw_hazard = 1'b0;
    if (ctrl.write_gpr_dest_alu && gpr_count[ctrl.gpr_dest_alu] > ALU_C) waw_hazard = 1'b1;
    if (ctrl.write_gpr_dest_mem && gpr_count[ctrl.gpr_dest_mem] > MEM_C) waw_hazard = 1'b1;
    for (int i = 0; i < NUM_CR_FIELDS; i++) begin
      if (ctrl.write_cr[i] && cr_count[i] > SPR_C) waw_hazard = 1'b1;
    end
    if (ctrl.write_ctr && ctr_count > SPR_C) waw_hazard = 1'b1;
    if (ctrl.write_lnk && lnk_count > SPR_C) waw_hazard = 1'b1;
    if (ctrl.write_xer && xer_count > SPR_C) waw_hazard = 1'b1;
  end

  // Slot lookup: reuse the slot already holding the id, else lowest free.
  always_comb begin
    spr_hit  = 1'b0;
    spr_free = 1'b0;
    hit_idx  = 0;
    free_idx = 0;
    for (int s = 0; s < SPR_SLOTS; s++) begin
      if (!spr_hit && slot_valid[s] && slot_id[s] == ctrl.write_spr_id) begin
        spr_hit = 1'b1;
        hit_idx = s;
      end
      if (!spr_free && !slot_valid[s]) begin
        spr_free = 1'b1;
        free_idx = s;
      end
    end
  end

  assign slot_hazard = ctrl.write_spr && !spr_hit && !spr_free;
  assign stall = ctrl.en && !flush && (read_hazard || waw_hazard || slot_hazard);
  assign issue = ctrl.en && !flush && !stall;

  // An ALU and a load destination naming the same GPR keep the longer latency.
  always_comb begin
    logic alu_hit, mem_hit;
    alu_hit = 1'b0;
    mem_hit = 1'b0;
    for (int i = 0; i < NUM_GPRS; i++) begin
      alu_hit = issue && ctrl.write_gpr_dest_alu && (ctrl.gpr_dest_alu == 5'(i));
      mem_hit = issue && ctrl.write_gpr_dest_mem && (ctrl.gpr_dest_mem == 5'(i));
      gpr_load[i]  = alu_hit || mem_hit;
      gpr_value[i] = (alu_hit && mem_hit) ? LONG_C : (mem_hit ? MEM_C : ALU_C);
    end
  end

  assign cr_load = issue ? ctrl.write_cr : '0;

  always_comb begin
    slot_load = '0;
    for (int s = 0; s < SPR_SLOTS; s++) begin
      if (issue && ctrl.write_spr) begin
        slot_load[s] = spr_hit ? (hit_idx == s) : (free_idx == s);
      end
    end
  end

  for (genvar g = 0; g < NUM_GPRS; g++) begin : g_gpr
    hazard_counter #(.W(CW)) u_cnt (
      .clk(clk), .reset(reset), .load(gpr_load[g]), .load_value(gpr_value[g]),
      .count(gpr_count[g]), .busy(busy_gpr[g])
    );
  end

  for (genvar g = 0; g < NUM_CR_FIELDS; g++) begin : g_cr
    hazard_counter #(.W(CW)) u_cnt (
      .clk(clk), .reset(reset), .load(cr_load[g]), .load_value(SPR_C),
      .count(cr_count[g]), .busy(cr_busy[g])
    );
  end

  hazard_counter #(.W(CW)) u_ctr (
    .clk(clk), .reset(reset), .load(issue && ctrl.write_ctr), .load_value(SPR_C),
    .count(ctr_count), .busy(ctr_busy)
  );
  hazard_counter #(.W(CW)) u_lnk (
    .clk(clk), .reset(reset), .load(issue && ctrl.write_lnk), .load_value(SPR_C),
    .count(lnk_count), .busy(lnk_busy)
  );
  hazard_counter #(.W(CW)) u_xer (
    .clk(clk), .reset(reset), .load(issue && ctrl.write_xer), .load_value(SPR_C),
    .count(xer_count), .busy(xer_busy)
  );

  // SPR slots: a slot drops its valid bit on the cycle its count hits zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SPR_SLOTS; s++) begin
        slot_valid[s] <= 1'b0;
        slot_id[s]    <= '0;
        slot_count[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SPR_SLOTS; s++) begin
        if (slot_load[s]) begin
          slot_valid[s] <= 1'b1;
          slot_id[s]    <= ctrl.write_spr_id;
          slot_count[s] <= SPR_C;
        end else if (slot_valid[s]) begin
          slot_count[s] <= slot_count[s] - ONE_C;
          slot_valid[s] <= (slot_count[s] > ONE_C);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_hazard_scoreboard.sv
module tb_data_hazard_scoreboard;

  localparam int ALU_LAT = 3;
  localparam int MEM_LAT = 5;
  localparam int SPR_LAT = 3;
  localparam int SLACK   = 0;
  localparam int SLOTS   = 2;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        stall;
  logic [31:0] busy_gpr;

  Data_hazard_ctrl_if ifc ();

  data_hazard_scoreboard dut (
    .clk(clk), .reset(reset), .ctrl(ifc), .flush(flush),
    .stall(stall), .busy_gpr(busy_gpr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: remaining cycles per resource ------
  int gpr_rem [32];
  int cr_rem  [8];
  int ctr_rem, lnk_rem, xer_rem;
  int spr_rem [16];   // indexed by SPR id, not by slot

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];   // {stall, busy_gpr}

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) gpr_rem[i] = 0;
    for (int i = 0; i < 8; i++) cr_rem[i] = 0;
    for (int i = 0; i < 16; i++) spr_rem[i] = 0;
    ctr_rem = 0; lnk_rem = 0; xer_rem = 0;
  endfunction

  function automatic int pending_sprs();
    int n = 0;
    for (int i = 0; i < 16; i++) if (spr_rem[i] > 0) n++;
    return n;
  endfunction

  function automatic logic model_stall();
    logic hz = 1'b0;
    if (!ifc.en || flush) return 1'b0;
    if (ifc.read_gpr_a && gpr_rem[ifc.gpr_a] > SLACK) hz = 1'b1;
    if (ifc.read_gpr_b && gpr_rem[ifc.gpr_b] > SLACK) hz = 1'b1;
    if (ifc.read_gpr_c && gpr_rem[ifc.gpr_c] > SLACK) hz = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((ifc.read_cr_0[i] || ifc.read_cr_1[i] || ifc.read_cr_2[i]) && cr_rem[i] > SLACK) hz = 1'b1;
      if (ifc.write_cr[i] && cr_rem[i] > SPR_LAT) hz = 1'b1;
    end
    if (ifc.read_ctr && ctr_rem > SLACK) hz = 1'b1;
    if (ifc.read_lnk && lnk_rem > SLACK) hz = 1'b1;
    if (ifc.read_xer && xer_rem > SLACK) hz = 1'b1;
    if (ifc.read_spr && spr_rem[ifc.read_spr_id] > SLACK) hz = 1'b1;
    if (ifc.read_spr2 && spr_rem[ifc.read_spr2_id] > SLACK) hz = 1'b1;
    if (ifc.write_gpr_dest_alu && gpr_rem[ifc.gpr_dest_alu] > ALU_LAT) hz = 1'b1;
    if (ifc.write_gpr_dest_mem && gpr_rem[ifc.gpr_dest_mem] > MEM_LAT) hz = 1'b1;
    if (ifc.write_ctr && ctr_rem > SPR_LAT) hz = 1'b1;
    if (ifc.write_lnk && lnk_rem > SPR_LAT) hz = 1'b1;
    if (ifc.write_xer && xer_rem > SPR_LAT) hz = 1'b1;
    if (ifc.write_spr && spr_rem[ifc.write_spr_id] == 0 && pending_sprs() >= SLOTS) hz = 1'b1;
    return hz;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = (gpr_rem[i] != 0);
    return b;
  endfunction

  function automatic void model_advance(input logic iss);
    for (int i = 0; i < 32; i++) if (gpr_rem[i] > 0) gpr_rem[i]--;
    for (int i = 0; i < 8; i++) if (cr_rem[i] > 0) cr_rem[i]--;
    for (int i = 0; i < 16; i++) if (spr_rem[i] > 0) spr_rem[i]--;
    if (ctr_rem > 0) ctr_rem--;
    if (lnk_rem > 0) lnk_rem--;
    if (xer_rem > 0) xer_rem--;
    if (!iss) return;
    if (ifc.write_gpr_dest_alu) gpr_rem[ifc.gpr_dest_alu] = ALU_LAT;
    if (ifc.write_gpr_dest_mem) gpr_rem[ifc.gpr_dest_mem] = MEM_LAT;
    if (ifc.write_gpr_dest_alu && ifc.write_gpr_dest_mem && ifc.gpr_dest_alu == ifc.gpr_dest_mem)
      gpr_rem[ifc.gpr_dest_alu] = (ALU_LAT > MEM_LAT) ? ALU_LAT : MEM_LAT;
    for (int i = 0; i < 8; i++) if (ifc.write_cr[i]) cr_rem[i] = SPR_LAT;
    if (ifc.write_ctr) ctr_rem = SPR_LAT;
    if (ifc.write_lnk) lnk_rem = SPR_LAT;
    if (ifc.write_xer) xer_rem = SPR_LAT;
    if (ifc.write_spr) spr_rem[ifc.write_spr_id] = SPR_LAT;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_ctrl();
    ifc.en = 1'b0;
    ifc.read_gpr_a = 1'b0; ifc.read_gpr_b = 1'b0; ifc.read_gpr_c = 1'b0;
    ifc.gpr_a = '0; ifc.gpr_b = '0; ifc.gpr_c = '0;
    ifc.read_cr_0 = '0; ifc.read_cr_1 = '0; ifc.read_cr_2 = '0;
    ifc.read_ctr = 1'b0; ifc.read_lnk = 1'b0; ifc.read_xer = 1'b0;
    ifc.read_spr = 1'b0; ifc.read_spr2 = 1'b0;
    ifc.read_spr_id = '0; ifc.read_spr2_id = '0;
    ifc.write_gpr_dest_alu = 1'b0; ifc.write_gpr_dest_mem = 1'b0;
    ifc.gpr_dest_alu = '0; ifc.gpr_dest_mem = '0;
    ifc.write_cr = '0;
    ifc.write_ctr = 1'b0; ifc.write_lnk = 1'b0; ifc.write_xer = 1'b0;
    ifc.write_spr = 1'b0; ifc.write_spr_id = '0;
    flush = 1'b0;
  endtask

  // Called just after a rising edge with inputs set; records the expected
  // response for this cycle and advances the model across the next edge.
  task automatic step();
    logic es;
    logic iss;
    es = model_stall();
    exp_q.push_back({es, model_busy()});
    iss = ifc.en && !flush && !es && !reset;
    @(posedge clk);
    if (reset) model_reset();
    else model_advance(iss);
    #1;
  endtask

  task automatic reset_mid_cycle();
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
  endtask

  task automatic randomize_ctrl();
    ifc.en = ($urandom_range(0, 3) != 0);
    flush = ($urandom_range(0, 15) == 0);
    ifc.read_gpr_a = $urandom_range(0, 1) != 0; ifc.gpr_a = 5'($urandom_range(0, 7));
    ifc.read_gpr_b = $urandom_range(0, 2) == 0; ifc.gpr_b = 5'($urandom_range(0, 7));
    ifc.read_gpr_c = $urandom_range(0, 4) == 0; ifc.gpr_c = 5'($urandom_range(0, 7));
    ifc.read_cr_0 = 8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255));
    ifc.read_cr_1 = 8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255));
    ifc.read_cr_2 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
    ifc.read_ctr = $urandom_range(0, 4) == 0;
    ifc.read_lnk = $urandom_range(0, 4) == 0;
    ifc.read_xer = $urandom_range(0, 4) == 0;
    ifc.read_spr = $urandom_range(0, 3) == 0;  ifc.read_spr_id = 4'($urandom_range(0, 3));
    ifc.read_spr2 = $urandom_range(0, 5) == 0; ifc.read_spr2_id = 4'($urandom_range(0, 3));
    ifc.write_gpr_dest_alu = $urandom_range(0, 1) != 0; ifc.gpr_dest_alu = 5'($urandom_range(0, 7));
    ifc.write_gpr_dest_mem = $urandom_range(0, 2) == 0; ifc.gpr_dest_mem = 5'($urandom_range(0, 7));
    ifc.write_cr = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
    ifc.write_ctr = $urandom_range(0, 5) == 0;
    ifc.write_lnk = $urandom_range(0, 5) == 0;
    ifc.write_xer = $urandom_range(0, 5) == 0;
    ifc.write_spr = $urandom_range(0, 2) == 0; ifc.write_spr_id = 4'($urandom_range(0, 3));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (stall !== e[32]) begin
        errors++;
        $display("FAIL stall at %0t: got %b expected %b", $time, stall, e[32]);
      end
      checks++;
      if (busy_gpr !== e[31:0]) begin
        errors++;
        $display("FAIL busy_gpr at %0t: got %h expected %h", $time, busy_gpr, e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    clear_ctrl();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Read with no history.
    clear_ctrl(); ifc.en = 1'b1; ifc.read_gpr_a = 1'b1; ifc.gpr_a = 5'd1; step();

    // ALU write r4, then read r4 until the countdown ends.
    clear_ctrl(); ifc.en = 1'b1; ifc.write_gpr_dest_alu = 1'b1; ifc.gpr_dest_alu = 5'd4; step();
    clear_ctrl(); ifc.en = 1'b1; ifc.read_gpr_b = 1'b1; ifc.gpr_b = 5'd4;
    repeat (5) step();

    // Load r5, then ALU write r5 (WAW).
    clear_ctrl(); ifc.en = 1'b1; ifc.write_gpr_dest_mem = 1'b1; ifc.gpr_dest_mem = 5'd5; step();
    clear_ctrl(); ifc.en = 1'b1; ifc.write_gpr_dest_alu = 1'b1; ifc.gpr_dest_alu = 5'd5;
    repeat (4) step();
    clear_ctrl(); repeat (6) step();

    // Same-instruction self read/write and ALU+load to one register.
    clear_ctrl(); ifc.en = 1'b1; ifc.read_gpr_a = 1'b1; ifc.gpr_a = 5'd3;
    ifc.write_gpr_dest_alu = 1'b1; ifc.gpr_dest_alu = 5'd3; step();
    clear_ctrl(); ifc.en = 1'b1; ifc.write_gpr_dest_alu = 1'b1; ifc.gpr_dest_alu = 5'd9;
    ifc.write_gpr_dest_mem = 1'b1; ifc.gpr_dest_mem = 5'd9; step();
    clear_ctrl(); ifc.en = 1'b1; ifc.read_gpr_c = 1'b1; ifc.gpr_c = 5'd9; repeat (6) step();

    // SPR slots: A, B, read A, C until a slot frees, then read unrelated D.
    clear_ctrl(); ifc.en = 1'b1; ifc.write_spr = 1'b1; ifc.write_spr_id = 4'd1; step();
    clear_ctrl(); ifc.en = 1'b1; ifc.write_spr = 1'b1; ifc.write_spr_id = 4'd2; step();
    clear_ctrl(); ifc.en = 1'b1; ifc.read_spr = 1'b1; ifc.read_spr_id = 4'd1; step();
    clear_ctrl(); ifc.en = 1'b1; ifc.write_spr = 1'b1; ifc.write_spr_id = 4'd3; repeat (3) step();
    clear_ctrl(); ifc.en = 1'b1; ifc.read_spr2 = 1'b1; ifc.read_spr2_id = 4'd4; step();
    clear_ctrl(); ifc.en = 1'b1; ifc.read_spr = 1'b1; ifc.read_spr_id = 4'd3; step();
    clear_ctrl(); repeat (4) step();

    // CR fields.
    clear_ctrl(); ifc.en = 1'b1; ifc.write_cr = 8'h01; step();
    clear_ctrl(); ifc.en = 1'b1; ifc.read_cr_1 = 8'h02; step();
    clear_ctrl(); ifc.en = 1'b1; ifc.read_cr_0 = 8'h01; step();
    clear_ctrl(); ifc.en = 1'b1; ifc.write_ctr = 1'b1; step();
    clear_ctrl(); ifc.en = 1'b1; ifc.read_ctr = 1'b1; repeat (4) step();

    // Flush keeps pending state and issues nothing; reset clears it.
    clear_ctrl(); ifc.en = 1'b1; ifc.write_gpr_dest_mem = 1'b1; ifc.gpr_dest_mem = 5'd7; step();
    clear_ctrl(); ifc.en = 1'b1; flush = 1'b1; ifc.read_gpr_a = 1'b1; ifc.gpr_a = 5'd7;
    ifc.write_gpr_dest_alu = 1'b1; ifc.gpr_dest_alu = 5'd8; step();
    clear_ctrl(); step();
    reset_mid_cycle();
    clear_ctrl(); ifc.en = 1'b1; ifc.read_gpr_a = 1'b1; ifc.gpr_a = 5'd7; step();
    ifc.gpr_a = 5'd8; step();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      clear_ctrl();
      randomize_ctrl();
      if ($urandom_range(0, 399) == 0) reset_mid_cycle();
      else step();
    end

    clear_ctrl();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_hazard_scoreboard.md
Name: data_hazard_scoreboard

Overview:
- Consumer end of Data_hazard_ctrl_if: the block connected to the data_hazard_ctrl modport.
- Tracks in-flight writes to GPRs, CR fields, CTR, LNK, XER and a small set of SPRs using per-resource countdown timers.
- Raises a stall to fetch/decode when the instruction presented by decode reads, or write-after-write conflicts with, a pending resource.
- Sits beside decode; stall feeds the fetch/decode hold logic.

Parameters:
ALU_LATENCY, 3, cycles from issue until an ALU result is written back
MEM_LATENCY, 5, cycles from issue until a load result is written back
SPR_LATENCY, 3, cycles from issue until SPR/CTR/LNK/XER/CR writes complete
READ_SLACK, 0, a read is allowed when the pending count is <= this value (bypass window)
SPR_SLOTS, 2, number of simultaneously tracked pending SPR writes

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
ctrl  interface  Data_hazard_ctrl_if.data_hazard_ctrl  resource usage of the instruction in decode; ctrl.en is the issue-valid
flush  input  1  suppresses the issue in this cycle; in-flight entries are kept
stall  output  1  hold decode this cycle (combinational)
busy_gpr  output  32  per-GPR pending flag (count != 0), for debug and bench

Behaviour:
- Counters:
  - 32 GPR counters, 8 CR-field counters, and one counter each for CTR, LNK and XER.
  - SPR_SLOTS slots, each holding {valid, Spr_reduced id, count}.
  - Width is clog2(max latency + 1).
- Reset: all counters 0 and all SPR slots invalid. Resulting output values: stall=0, busy_gpr=0.
- Every cycle, each nonzero counter decrements by 1, saturating at 0. An SPR slot becomes invalid when its count reaches 0.
- Read hazard: any asserted read whose target count > READ_SLACK. This covers:
  - GPR a, b, c via read_gpr_x with gpr_x;
  - each set bit of read_cr_0, read_cr_1 or read_cr_2 against its CR field;
  - read_ctr, read_lnk, read_xer;
  - read_spr/read_spr2 matching the id of a valid slot.
- WAW hazard: a write whose target count > its new latency.
  - Example: a load pending on r5 followed by an ALU write to r5.
  - An alu and mem destination in the same instruction that target the same reg also count as a WAW hazard, resolved to the longer latency.
- No SPR slot free for write_spr: counts as a hazard.
- stall = ctrl.en & ~flush & (read hazard | WAW hazard | no SPR slot). stall is 0 whenever en=0.
- Issue: occurs when ctrl.en & ~flush & ~stall. The issue loads the following into the written targets, overriding that cycle's decrement:
  - write_gpr_dest_alu: ALU_LATENCY;
  - write_gpr_dest_mem: MEM_LATENCY;
  - write_cr bits, ctr, lnk, xer: SPR_LATENCY;
  - write_spr: allocates the lowest free slot, or reuses a slot already holding the same id.
- Same-cycle read and write by one instruction, such as r3 = r3 + 1: the read check uses the pre-issue state, so there is no self-stall.
- A counter expiring (1 -> 0) in the same cycle as a read: the check uses the registered value, so with READ_SLACK=0 the stall persists for that cycle and clears on the next.
- Latency: stall is combinational from ctrl. Pending state is visible one cycle after issue.
- Reset asserted mid-operation clears all pending state immediately and asynchronously.

Decomposition:
- Pu_types, shared package:
  - Reg_index, Spr_reduced and Fu_port (already present);
  - a new Hazard_count typedef;
  - a NUM_CR_FIELDS=8 constant.
- Natural sub-module: hazard_counter, a single loadable saturating down-counter with a busy flag, instantiated per resource. The SPR slot array stays inline.

Test Plan:
- Reset, then en=1 reading r1 with no history -> stall=0 and busy_gpr=0.
- Issue an ALU write to r4, then next cycle read r4 -> stall=1 for 3 cycles (counts 3, 2, 1), stall=0 on the 4th, busy_gpr[4] clears in step.
- Issue a load to r5, then the next instruction does an ALU write to r5 -> WAW stall until the r5 count <= 3, i.e. 2 stall cycles.
- Issue write_spr to id A and then to id B, then a third write_spr to id C -> stall until one slot expires. read_spr of A stalls, read_spr of unrelated id D does not.
- write_cr=8'h01 issued, then read_cr_1=8'h02 -> no stall. Then read_cr_0=8'h01 -> stall.
- Load to r7 pending, flush=1 with en=1 -> stall=0 and no new entry. Assert reset mid-countdown -> busy_gpr=0 immediately, and a read of r7 afterwards gives stall=0.
